// File: rtl/sample_decimator_pkg.sv
// Shared constants, encodings and helpers for the sample decimator.
package sample_decimator_pkg;

    localparam int DEC_SAMPLE_W = 16;
    localparam int DEC_MAX_LOG2 = 7;
    localparam int DEC_ACC_W    = DEC_SAMPLE_W + DEC_MAX_LOG2;

    localparam logic MODE_AVG = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic {
        DEC_IDLE  = 1'b0,
        DEC_ACCUM = 1'b1
    } dec_state_e;

    // Ratios beyond what the accumulator can hold are pinned to the maximum.
    function automatic logic [2:0] clamp_ratio(input logic [2:0] r, input int max_log2);
        if (int'(r) > max_log2) begin
            return 3'(max_log2);
        end
        return r;
    endfunction

endpackage

// File: rtl/decim_accumulator.sv
// Group accumulator: running sum and sample count with terminal-count compare.
module decim_accumulator
    import sample_decimator_pkg::*;
#(
    parameter int SAMPLE_W = DEC_SAMPLE_W,
    parameter int MAX_LOG2 = DEC_MAX_LOG2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 accept_i,
    input  logic signed [SAMPLE_W-1:0]           sample_i,
    input  logic [2:0]                           ratio_i,
    output logic signed [SAMPLE_W+MAX_LOG2-1:0]  sum_o,
    output logic                                 last_o
);

    localparam int ACC_W = SAMPLE_W + MAX_LOG2;
    localparam int CNT_W = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0] cnt_q, cnt_d;
    logic signed [ACC_W-1:0] sample_ext;
    logic        [CNT_W-1:0] term_cnt;

    always_comb begin
        sample_ext = {{(ACC_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i};
        sum_o      = acc_q + sample_ext;
        // N-1 as a mask of ratio_i low ones; zero when the ratio is 0.
        term_cnt   = ~({CNT_W{1'b1}} << ratio_i);
        last_o     = (cnt_q == term_cnt);

        acc_d = acc_q;
        cnt_d = cnt_q;
        if (accept_i) begin
            if (last_o) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_o;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sample_decimator.sv
// Sample-rate decimator by 2^ratio_sel, boxcar average or last-of-group subsample.
//   state     | meaning
//   DEC_IDLE  | no partial group; ratio_sel/mode are live
//   DEC_ACCUM | group in progress; latched ratio/mode in use
module sample_decimator
    import sample_decimator_pkg::*;
#(
    parameter int SAMPLE_W = DEC_SAMPLE_W,
    parameter int MAX_LOG2 = DEC_MAX_LOG2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       new_sample_in,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic [2:0]                 ratio_sel,
    input  logic                       mode,
    input  logic                       hold,
    output logic                       new_sample_out,
    output logic signed [SAMPLE_W-1:0] sample_out,
    output logic                       busy,
    output logic [2:0]                 active_ratio
);

    localparam int ACC_W = SAMPLE_W + MAX_LOG2;

    dec_state_e              state_q, state_d;
    logic [2:0]              ratio_q, ratio_d;
    logic                    mode_q, mode_d;
    logic                    strobe_q, strobe_d;
    logic signed [SAMPLE_W-1:0] out_q, out_d;

    logic                    accept;
    logic [2:0]              eff_ratio;
    logic                    eff_mode;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    acc_last;

    decim_accumulator #(
        .SAMPLE_W (SAMPLE_W),
        .MAX_LOG2 (MAX_LOG2)
    ) u_acc (
        .clk      (clk),
        .reset    (reset),
        .accept_i (accept),
        .sample_i (sample_in),
        .ratio_i  (eff_ratio),
        .sum_o    (acc_sum),
        .last_o   (acc_last)
    );

    always_comb begin
        accept    = new_sample_in && !hold;
        eff_ratio = (state_q == DEC_IDLE) ? clamp_ratio(ratio_sel, MAX_LOG2) : ratio_q;
        eff_mode  = (state_q == DEC_IDLE) ? mode : mode_q;

        state_d  = state_q;
        ratio_d  = ratio_q;
        mode_d   = mode_q;
        strobe_d = 1'b0;
        out_d    = out_q;

        if (accept) begin
            if (state_q == DEC_IDLE) begin
                ratio_d = eff_ratio;
                mode_d  = eff_mode;
            end
            if (acc_last) begin
                strobe_d = 1'b1;
                state_d  = DEC_IDLE;
                // Arithmetic shift floors the mean; the result always fits SAMPLE_W.
                out_d    = (eff_mode == MODE_AVG) ? SAMPLE_W'(acc_sum >>> eff_ratio) : sample_in;
            end else begin
                state_d  = DEC_ACCUM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= DEC_IDLE;
            ratio_q  <= '0;
            mode_q   <= MODE_AVG;
            strobe_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            ratio_q  <= ratio_d;
            mode_q   <= mode_d;
            strobe_q <= strobe_d;
            out_q    <= out_d;
        end
    end

    assign new_sample_out = strobe_q;
    assign sample_out     = out_q;
    assign busy           = (state_q == DEC_ACCUM);
    assign active_ratio   = ratio_q;

endmodule

// File: tb/tb_sample_decimator.sv
// Directed and randomized bench for sample_decimator against a group-level reference model.
module tb_sample_decimator;

    logic               clk;
    logic               reset;
    logic               new_sample_in;
    logic signed [15:0] sample_in;
    logic [2:0]         ratio_sel;
    logic               mode;
    logic               hold;
    logic               new_sample_out;
    logic signed [15:0] sample_out;
    logic               busy;
    logic [2:0]         active_ratio;

    sample_decimator dut (
        .clk            (clk),
        .reset          (reset),
        .new_sample_in  (new_sample_in),
        .sample_in      (sample_in),
        .ratio_sel      (ratio_sel),
        .mode           (mode),
        .hold           (hold),
        .new_sample_out (new_sample_out),
        .sample_out     (sample_out),
        .busy           (busy),
        .active_ratio   (active_ratio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    string phase = "init";

    // Reference model: the samples of the open group, plus expected outputs.
    int                 grp_q[$];
    logic [2:0]         exp_ratio = '0;
    bit                 grp_mode = 1'b0;
    bit                 exp_strobe = 1'b0;
    logic signed [15:0] exp_out = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model(input bit strb, input int val, input bit [2:0] rs,
                         input bit md, input bit hld, input bit rstb);
        longint s, n, a;
        if (!rstb) begin
            grp_q.delete();
            exp_ratio  = '0;
            grp_mode   = 1'b0;
            exp_strobe = 1'b0;
            exp_out    = '0;
            return;
        end
        exp_strobe = 1'b0;
        if (strb && !hld) begin
            if (grp_q.size() == 0) begin
                exp_ratio = rs;
                grp_mode  = md;
            end
            grp_q.push_back(val);
            n = longint'(1) << exp_ratio;
            if (longint'(grp_q.size()) == n) begin
                s = 0;
                foreach (grp_q[i]) s += grp_q[i];
                if (grp_mode) begin
                    a = grp_q[grp_q.size()-1];
                end else if (s >= 0) begin
                    a = s / n;
                end else begin
                    a = -((-s + n - 1) / n);
                end
                exp_out    = 16'(a);
                exp_strobe = 1'b1;
                grp_q.delete();
            end
        end
    endtask

    task automatic step(input bit strb, input int val, input bit [2:0] rs,
                        input bit md, input bit hld, input bit rstb);
        new_sample_in = strb;
        sample_in     = 16'(val);
        ratio_sel     = rs;
        mode          = md;
        hold          = hld;
        reset         = rstb;
        model(strb, val, rs, md, hld, rstb);
        @(posedge clk);
        #1;
        check({phase, " strobe"},       32'(new_sample_out), 32'(exp_strobe));
        check({phase, " sample_out"},   32'(sample_out),     32'(exp_out));
        check({phase, " busy"},         32'(busy),           32'(grp_q.size() != 0));
        check({phase, " active_ratio"}, 32'(active_ratio),   32'(exp_ratio));
    endtask

    task automatic idle(input bit [2:0] rs, input bit md);
        step(1'b0, 0, rs, md, 1'b0, 1'b1);
    endtask

    initial begin
        bit [2:0]           rs;
        bit                 md;
        logic signed [15:0] v;

        new_sample_in = 1'b0;
        sample_in     = '0;
        ratio_sel     = '0;
        mode          = 1'b0;
        hold          = 1'b0;
        reset         = 1'b0;

        phase = "reset";
        step(1'b0, 0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 77, 3'd2, 1'b1, 1'b0, 1'b0);

        phase = "ratio0";
        step(1'b1, 100, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, -5, 3'd0, 1'b0, 1'b0, 1'b1);
        idle(3'd0, 1'b0);

        phase = "avg4";
        step(1'b1, 10, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 20, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 30, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 41, 3'd2, 1'b0, 1'b0, 1'b1);
        idle(3'd2, 1'b0);
        phase = "avg4_neg";
        step(1'b1, -1, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, -1, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, -1, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, -2, 3'd2, 1'b0, 1'b0, 1'b1);
        idle(3'd2, 1'b0);

        phase = "sub8";
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, i, (i <= 3) ? 3'd3 : 3'd1, (i <= 3) ? 1'b1 : 1'b0, 1'b0, 1'b1);
        end
        idle(3'd1, 1'b1);
        phase = "sub2";
        step(1'b1, 5, 3'd1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 7, 3'd1, 1'b1, 1'b0, 1'b1);
        idle(3'd1, 1'b1);

        phase = "max_pos";
        for (int i = 0; i < 128; i++) step(1'b1, 32767, 3'd7, 1'b0, 1'b0, 1'b1);
        idle(3'd7, 1'b0);
        phase = "max_neg";
        for (int i = 0; i < 128; i++) step(1'b1, -32768, 3'd7, 1'b0, 1'b0, 1'b1);
        idle(3'd7, 1'b0);

        phase = "hold";
        step(1'b1, 4, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 4, 3'd2, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1000, 3'd2, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8, 3'd2, 1'b0, 1'b0, 1'b1);
        idle(3'd2, 1'b0);

        phase = "reset_mid";
        for (int i = 0; i < 3; i++) step(1'b1, 50, 3'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, 50, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 12, 3'd2, 1'b0, 1'b0, 1'b1);
        idle(3'd2, 1'b0);

        phase = "random";
        rs = 3'd1;
        md = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) rs = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) md = 1'($urandom_range(0, 1));
            v = 16'($urandom());
            step($urandom_range(0, 3) != 0, int'(v), rs, md,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 299) != 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sample_decimator.md
Name: sample_decimator

Overview:
Upstream conditioning stage for the waveform display path. It sits between the codec sample stream and the display top's new_sample/sample inputs. It reduces the sample rate by 2^ratio_sel using either boxcar averaging or plain subsampling. This stretches the displayed timebase without touching capture or RAM logic.

Parameters:
SAMPLE_W, 16, width of signed two's-complement input/output samples
MAX_LOG2, 7, maximum log2 decimation ratio (ratio up to 128)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset (reset==0 at a rising edge resets the block)
new_sample_in  input  1  one-cycle strobe, sample_in valid
sample_in  input  SAMPLE_W  signed input sample
ratio_sel  input  3  log2 decimation ratio N=2^ratio_sel, 0..MAX_LOG2
mode  input  1  0 = average, 1 = subsample (last sample of group)
hold  input  1  1 = ignore incoming strobes, freeze the partial group
new_sample_out  output  1  one-cycle strobe, sample_out updated
sample_out  output  SAMPLE_W  decimated signed sample, held between strobes
busy  output  1  1 while a partial group is in progress (state ACCUM)
active_ratio  output  3  ratio latched for the current/last group

Behaviour:
- Reset (reset==0 at posedge): state IDLE, acc=0, cnt=0, new_sample_out=0, sample_out=0, busy=0, active_ratio=0, latched mode=0.
- Accept condition: new_sample_in==1 && hold==0. Throughput is 1 sample per clock; back-to-back strobes are legal.
- Accumulator width ACC_W = SAMPLE_W+MAX_LOG2 (23), signed; sample_in is sign-extended before adding. No overflow is possible.
- State IDLE (cnt==0):
  - ratio_sel and mode are live.
  - On accept: latch active_ratio<=ratio_sel and mode. If ratio_sel==0, complete the group immediately. Otherwise acc<=sext(sample_in), cnt<=1, go to ACCUM.
- State ACCUM:
  - ratio_sel and mode changes are ignored until the group completes.
  - On accept with cnt < N-1: acc+=sample_in, cnt+=1.
  - On accept with cnt==N-1: complete the group, acc<=0, cnt<=0, go to IDLE.
- Group completion, registered with latency 1:
  - The cycle after the accepting edge, new_sample_out=1 for exactly one cycle.
  - sample_out = (acc+sext(sample_in)) >>> active_ratio in average mode: arithmetic shift, rounds toward -inf, low SAMPLE_W bits. The result always fits.
  - sample_out = sample_in of the final accepted sample in subsample mode.
- sample_out holds its value between strobes. new_sample_out is never high for 2 consecutive cycles unless N==1 and input strobes are back-to-back.
- busy = (state==ACCUM).
- hold==1: strobes are dropped; acc, cnt and state are frozen; a pending completion strobe already registered still fires. Releasing hold resumes the group where it left off.
- ratio_sel > MAX_LOG2: not possible with 3 bits at default. If MAX_LOG2 < 7, clamp to MAX_LOG2.
- Reset mid-group: the partial group is discarded; no output strobe is emitted.
- Reset asserted in the same cycle as an accept: reset wins.

Decomposition:
- Shared package holds:
  - SAMPLE_W, MAX_LOG2 and derived ACC_W constants.
  - Mode encodings MODE_AVG=1'b0, MODE_SUB=1'b1.
  - State encoding DEC_IDLE/DEC_ACCUM.
- One natural sub-module: decim_accumulator. It holds the acc/cnt registers, the sign-extend-and-add logic and the terminal-count compare, and is shared by both modes.
- The FSM, ratio/mode latching and output register stay in the top module.

Test Plan:
- Reset, then ratio_sel=0, mode=0, strobes with 100 then -5 -> two out strobes, each 1 cycle after input, sample_out=100 then -5; busy stays 0.
- ratio_sel=2, mode=0, back-to-back samples 10,20,30,41 -> one strobe after 4th accept, sample_out=25 (101>>>2); inputs -1,-1,-1,-2 -> sample_out=-2 (round toward -inf).
- ratio_sel=3, mode=1, samples 1..8 -> single strobe, sample_out=8. Change ratio_sel to 1 after the 3rd sample -> ignored; active_ratio=3 until group ends, next group uses 1.
- ratio_sel=7, all samples 32767 (128 of them) -> sample_out=32767; all -32768 -> sample_out=-32768 (no overflow).
- ratio_sel=2, accept 2 samples, hold=1 with 3 strobes, hold=0, 2 more samples (values 4,4,ignored x3,8,8) -> one strobe, sample_out=6; busy=1 throughout hold.
- ratio_sel=2, accept 3 samples, reset=0 for one cycle, then 4 samples of 12 -> no strobe from the partial group; one strobe with sample_out=12.
